// File: rtl/writeback_arbiter.sv
// Write-back arbiter: merges ALU/FPU and load results into one in-order FIFO
// and retires at most one register-file write per cycle. Also answers hazard
// queries for registers whose write is still queued or currently strobing.
module writeback_arbiter #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic                       clock,
    input  logic                       reset,

    input  logic                       alu_valid,
    output logic                       alu_ready,
    input  logic [REG_W-1:0]           alu_rd,
    input  logic [DATA_W-1:0]          alu_data,
    input  logic                       alu_float,

    input  logic                       mem_valid,
    output logic                       mem_ready,
    input  logic [REG_W-1:0]           mem_rd,
    input  logic [DATA_W-1:0]          mem_data,
    input  logic                       mem_float,

    input  logic                       stall,
    output logic [REG_W-1:0]           write_reg,
    output logic [DATA_W-1:0]          write_data,
    output logic                       regwrite,
    output logic                       regwrite_float,
    output logic [$clog2(DEPTH):0]     count,

    input  logic [REG_W-1:0]           query_rs1,
    input  logic [REG_W-1:0]           query_rs2,
    input  logic                       query_float,
    output logic                       pending_rs1,
    output logic                       pending_rs2
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Occupancy limits: one free slot admits a single producer, two free
    // slots are needed before the ALU may go alongside a load.
    localparam logic [CW-1:0] LIM_ONE = CW'(DEPTH - 1);
    localparam logic [CW-1:0] LIM_TWO = CW'(DEPTH - 2);

    // FIFO storage
    logic [REG_W-1:0]  rd_mem_q   [DEPTH];
    logic [REG_W-1:0]  rd_mem_d   [DEPTH];
    logic [DATA_W-1:0] data_mem_q [DEPTH];
    logic [DATA_W-1:0] data_mem_d [DEPTH];
    logic              flt_mem_q  [DEPTH];
    logic              flt_mem_d  [DEPTH];

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;

    // Output stage
    logic [REG_W-1:0]  write_reg_q, write_reg_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;
    logic              regwrite_q, regwrite_d;
    logic              regwrite_float_q, regwrite_float_d;

    logic              enq_mem;
    logic              enq_alu;
    logic              pop;
    logic [PW-1:0]     alu_slot;
    logic [PW-1:0]     q_slot;

    // Ready is a pure function of current occupancy; a pop on the same edge
    // does not free space early. Both readies are forced low during reset.
    always_comb begin
        mem_ready = !reset && (count_q <= LIM_ONE);
        alu_ready = !reset && (mem_valid ? (count_q <= LIM_TWO) : (count_q <= LIM_ONE));
    end

    // Enqueue/pop decisions and next-state for FIFO, pointers and output stage.
    // Integer writes to x0 complete the handshake but are dropped here.
    always_comb begin
        enq_mem  = mem_valid && mem_ready && (mem_float || (mem_rd != '0));
        enq_alu  = alu_valid && alu_ready && (alu_float || (alu_rd != '0));
        pop      = (count_q != '0) && !stall;

        rd_mem_d   = rd_mem_q;
        data_mem_d = data_mem_q;
        flt_mem_d  = flt_mem_q;

        // Load goes first so it drains ahead of a same-edge ALU result.
        alu_slot = wr_ptr_q + PW'(enq_mem);
        if (enq_mem) begin
            rd_mem_d[wr_ptr_q]   = mem_rd;
            data_mem_d[wr_ptr_q] = mem_data;
            flt_mem_d[wr_ptr_q]  = mem_float;
        end
        if (enq_alu) begin
            rd_mem_d[alu_slot]   = alu_rd;
            data_mem_d[alu_slot] = alu_data;
            flt_mem_d[alu_slot]  = alu_float;
        end

        wr_ptr_d = wr_ptr_q + PW'(enq_mem) + PW'(enq_alu);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(enq_mem) + CW'(enq_alu) - CW'(pop);

        // Index and data hold their last value when nothing is popped.
        write_reg_d      = write_reg_q;
        write_data_d     = write_data_q;
        regwrite_d       = 1'b0;
        regwrite_float_d = 1'b0;
        if (pop) begin
            write_reg_d      = rd_mem_q[rd_ptr_q];
            write_data_d     = data_mem_q[rd_ptr_q];
            regwrite_d       = !flt_mem_q[rd_ptr_q];
            regwrite_float_d = flt_mem_q[rd_ptr_q];
        end
    end

    // State registers with synchronous reset; reset discards every entry.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                rd_mem_q[i]   <= '0;
                data_mem_q[i] <= '0;
                flt_mem_q[i]  <= 1'b0;
            end
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            count_q          <= '0;
            write_reg_q      <= '0;
            write_data_q     <= '0;
            regwrite_q       <= 1'b0;
            regwrite_float_q <= 1'b0;
        end else begin
            rd_mem_q         <= rd_mem_d;
            data_mem_q       <= data_mem_d;
            flt_mem_q        <= flt_mem_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            count_q          <= count_d;
            write_reg_q      <= write_reg_d;
            write_data_q     <= write_data_d;
            regwrite_q       <= regwrite_d;
            regwrite_float_q <= regwrite_float_d;
        end
    end

    // Hazard lookup over live FIFO entries plus the strobing output stage.
    // Integer x0 is hard-wired and never reported pending.
    always_comb begin
        pending_rs1 = 1'b0;
        pending_rs2 = 1'b0;
        q_slot      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            q_slot = rd_ptr_q + PW'(i);
            if ((CW'(i) < count_q) && (flt_mem_q[q_slot] == query_float)) begin
                if (rd_mem_q[q_slot] == query_rs1) pending_rs1 = 1'b1;
                if (rd_mem_q[q_slot] == query_rs2) pending_rs2 = 1'b1;
            end
        end
        if ((regwrite_q || regwrite_float_q) && (regwrite_float_q == query_float)) begin
            if (write_reg_q == query_rs1) pending_rs1 = 1'b1;
            if (write_reg_q == query_rs2) pending_rs2 = 1'b1;
        end
        if (!query_float && (query_rs1 == '0)) pending_rs1 = 1'b0;
        if (!query_float && (query_rs2 == '0)) pending_rs2 = 1'b0;
    end

    assign write_reg      = write_reg_q;
    assign write_data     = write_data_q;
    assign regwrite       = regwrite_q;
    assign regwrite_float = regwrite_float_q;
    assign count          = count_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: accepted writes are pushed to an
// expected queue; a negedge monitor pops and compares every strobe.
module tb_writeback_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        alu_valid, alu_float, mem_valid, mem_float;
    logic        alu_ready, mem_ready;
    logic [4:0]  alu_rd, mem_rd;
    logic [31:0] alu_data, mem_data;
    logic        stall;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        regwrite, regwrite_float;
    logic [2:0]  count;
    logic [4:0]  query_rs1, query_rs2;
    logic        query_float;
    logic        pending_rs1, pending_rs2;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        flt;
    } exp_t;
    exp_t exp_q[$];

    writeback_arbiter #(.DEPTH(4), .DATA_W(32), .REG_W(5)) dut (
        .clock(clock), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd),
        .alu_data(alu_data), .alu_float(alu_float),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd),
        .mem_data(mem_data), .mem_float(mem_float),
        .stall(stall), .write_reg(write_reg), .write_data(write_data),
        .regwrite(regwrite), .regwrite_float(regwrite_float), .count(count),
        .query_rs1(query_rs1), .query_rs2(query_rs2), .query_float(query_float),
        .pending_rs1(pending_rs1), .pending_rs2(pending_rs2)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Monitor: every strobe must match the oldest expected write.
    always @(negedge clock) begin
        if (!reset && (regwrite || regwrite_float)) begin
            checks++;
            if (regwrite && regwrite_float) begin
                failures++;
                $display("FAIL strobe_both regwrite=%0b regwrite_float=%0b", regwrite, regwrite_float);
            end else if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_strobe reg=%0d data=%0h float=%0b", write_reg, write_data, regwrite_float);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (write_reg !== e.rd || write_data !== e.data || regwrite_float !== e.flt) begin
                    failures++;
                    $display("FAIL strobe_data actual reg=%0d data=%0h float=%0b expected reg=%0d data=%0h float=%0b",
                             write_reg, write_data, regwrite_float, e.rd, e.data, e.flt);
                end
            end
        end
    end

    function automatic logic dropped(input logic [4:0] rd, input logic flt);
        return (rd == 5'd0) && !flt;
    endfunction

    task automatic send_alu(input logic [4:0] rd, input logic [31:0] data, input logic flt);
        int n = 0;
        alu_valid = 1'b1; alu_rd = rd; alu_data = data; alu_float = flt;
        #0;
        while (!alu_ready && n < 100) begin tick(); n++; end
        if (!alu_ready) begin
            checks++; failures++;
            $display("FAIL alu_ready_timeout actual=0 expected=1");
        end else if (!dropped(rd, flt)) begin
            exp_q.push_back('{rd: rd, data: data, flt: flt});
        end
        tick();
        alu_valid = 1'b0;
    endtask

    task automatic send_mem(input logic [4:0] rd, input logic [31:0] data, input logic flt);
        int n = 0;
        mem_valid = 1'b1; mem_rd = rd; mem_data = data; mem_float = flt;
        #0;
        while (!mem_ready && n < 100) begin tick(); n++; end
        if (!mem_ready) begin
            checks++; failures++;
            $display("FAIL mem_ready_timeout actual=0 expected=1");
        end else if (!dropped(rd, flt)) begin
            exp_q.push_back('{rd: rd, data: data, flt: flt});
        end
        tick();
        mem_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0) && n < 50) begin tick(); n++; end
        tick(); tick();
        check("drain_queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0; alu_float = 1'b0;
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0; mem_float = 1'b0;
        query_rs1 = '0; query_rs2 = '0; query_float = 1'b0;
        tick(); tick();
        alu_valid = 1'b1; mem_valid = 1'b1;
        #1;
        check("reset_alu_ready", alu_ready, 0);
        check("reset_mem_ready", mem_ready, 0);
        check("reset_count", count, 0);
        check("reset_regwrite", regwrite, 0);
        check("reset_regwrite_float", regwrite_float, 0);
        check("reset_write_reg", write_reg, 0);
        check("reset_write_data", write_data, 0);
        alu_valid = 1'b0; mem_valid = 1'b0;
        reset = 1'b0;
        tick();

        // Single ALU write: latency and one-cycle strobe
        send_alu(5'd5, 32'h11, 1'b0);
        check("lat_count_after_accept", count, 1);
        check("lat_no_strobe_yet", regwrite, 0);
        tick();
        check("lat_regwrite", regwrite, 1);
        check("lat_regwrite_float", regwrite_float, 0);
        check("lat_write_reg", write_reg, 5);
        check("lat_write_data", write_data, 32'h11);
        tick();
        check("lat_strobe_dropped", regwrite, 0);
        check("lat_reg_held", write_reg, 5);

        // Same-edge mem + alu: load first
        mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'hAA; mem_float = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'hBB; alu_float = 1'b0;
        #1;
        check("both_alu_ready", alu_ready, 1);
        check("both_mem_ready", mem_ready, 1);
        exp_q.push_back('{rd: 5'd3, data: 32'hAA, flt: 1'b0});
        exp_q.push_back('{rd: 5'd4, data: 32'hBB, flt: 1'b0});
        tick();
        mem_valid = 1'b0; alu_valid = 1'b0;
        check("both_count2", count, 2);
        tick();
        check("both_count1", count, 1);
        check("both_first_reg", write_reg, 3);
        tick();
        check("both_count0", count, 0);
        check("both_second_reg", write_reg, 4);
        drain();

        // Fill under stall
        stall = 1'b1;
        send_alu(5'd8,  32'h80, 1'b0);
        send_alu(5'd9,  32'h90, 1'b0);
        send_mem(5'd10, 32'hA0, 1'b0);
        send_alu(5'd11, 32'hB0, 1'b0);
        check("full_count", count, 4);
        check("full_alu_ready", alu_ready, 0);
        check("full_mem_ready", mem_ready, 0);
        check("full_no_strobe", regwrite, 0);
        query_float = 1'b0;
        for (int r = 8; r <= 11; r++) begin
            query_rs1 = 5'(r);
            #1;
            check($sformatf("full_pending_rd%0d", r), pending_rs1, 1);
        end
        query_rs1 = 5'd12; query_rs2 = 5'd11;
        #1;
        check("full_not_pending_rd12", pending_rs1, 0);
        check("full_pending_rs2_rd11", pending_rs2, 1);
        query_float = 1'b1;
        #1;
        check("full_float_class_differs", pending_rs2, 0);
        query_float = 1'b0;
        stall = 1'b0;
        tick();
        check("unfull_count", count, 3);
        check("unfull_mem_ready", mem_ready, 1);
        drain();

        // x0 handling
        send_alu(5'd0, 32'h55, 1'b0);
        check("x0_int_count", count, 0);
        tick(); tick();
        send_alu(5'd0, 32'h66, 1'b1);
        check("x0_float_count", count, 1);
        tick();
        check("x0_float_strobe", regwrite_float, 1);
        check("x0_float_reg", write_reg, 0);
        check("x0_int_no_strobe", regwrite, 0);
        drain();

        // Hazard query across register classes
        stall = 1'b1;
        send_alu(5'd7, 32'h70, 1'b0);
        send_mem(5'd7, 32'h71, 1'b1);
        query_rs1 = 5'd7; query_float = 1'b0;
        #1;
        check("haz_int_rd7", pending_rs1, 1);
        query_float = 1'b1;
        #1;
        check("haz_float_rd7", pending_rs1, 1);
        query_rs2 = 5'd0; query_float = 1'b0;
        #1;
        check("haz_x0_never", pending_rs2, 0);
        stall = 1'b0;
        drain();
        query_float = 1'b0;
        #1;
        check("haz_int_cleared", pending_rs1, 0);
        query_float = 1'b1;
        #1;
        check("haz_float_cleared", pending_rs1, 0);

        // Reset mid-operation
        stall = 1'b1;
        send_alu(5'd12, 32'hC0, 1'b0);
        send_alu(5'd13, 32'hD0, 1'b0);
        send_alu(5'd14, 32'hE0, 1'b1);
        check("pre_reset_count", count, 3);
        reset = 1'b1;
        alu_valid = 1'b1; mem_valid = 1'b1;
        #1;
        check("midreset_alu_ready", alu_ready, 0);
        check("midreset_mem_ready", mem_ready, 0);
        exp_q.delete();
        tick();
        alu_valid = 1'b0; mem_valid = 1'b0;
        reset = 1'b0;
        stall = 1'b0;
        check("post_reset_count", count, 0);
        check("post_reset_regwrite", regwrite, 0);
        for (int k = 0; k < 6; k++) tick();
        check("post_reset_still_empty", count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
